// File: rtl/npc_pkg.sv
// npc_pkg: types and constants shared by the writeback stage.
//   XLEN        - datapath width of the integer pipeline.
//   load_op_e   - funct3 encoding of load instructions (7 is unused).
//   wb_state_e  - writeback stage control states.
package npc_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LD  = 3'd3,
        LBU = 3'd4,
        LHU = 3'd5,
        LWU = 3'd6
    } load_op_e;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_unit_load_ext.sv
// load_ext: selects the addressed byte/halfword/word out of an aligned
// doubleword and sign- or zero-extends it to XLEN.
//   rdata    in  XLEN  aligned doubleword from data memory
//   addr_lo  in  3     load address bits [2:0]
//   load_op  in  3     funct3 load encoding
//   result   out XLEN  extended load value (0 for the unused encoding 7)
module load_ext #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr_lo,
    input  logic [2:0]      load_op,
    output logic [XLEN-1:0] result
);
    import npc_pkg::*;

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;
    logic [5:0]  byte_sel;
    logic [5:0]  half_sel;
    logic [5:0]  word_sel;

    // Address bits below the access size are dropped; misalignment is
    // handled before the instruction reaches this stage.
    assign byte_sel = {addr_lo, 3'b000};
    assign half_sel = {addr_lo[2:1], 4'b0000};
    assign word_sel = {addr_lo[2], 5'b00000};

    assign byte_v = rdata[byte_sel +: 8];
    assign half_v = rdata[half_sel +: 16];
    assign word_v = rdata[word_sel +: 32];

    always_comb begin
        result = '0;
        case (load_op_e'(load_op))
            LB:      result = {{(XLEN-8){byte_v[7]}}, byte_v};
            LH:      result = {{(XLEN-16){half_v[15]}}, half_v};
            LW:      result = {{(XLEN-32){word_v[31]}}, word_v};
            LD:      result = rdata;
            LBU:     result = {{(XLEN-8){1'b0}}, byte_v};
            LHU:     result = {{(XLEN-16){1'b0}}, half_v};
            LWU:     result = {{(XLEN-32){1'b0}}, word_v};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback stage in front of the integer register file write port.
// Accepts one retiring instruction at a time, waits for load data when needed,
// and produces a registered single-cycle RF write plus commit/forward copies.
//   clock, reset            clock (rising edge), async active-low reset
//   ex_valid/ex_ready       retiring-instruction handshake
//   ex_pc, ex_rd, ex_wen    instruction PC, destination, write intent
//   ex_is_load, ex_load_op, ex_addr_lo   load descriptor
//   ex_result               ALU/CSR result for non-loads
//   mem_rvalid, mem_rdata   load data response (aligned doubleword)
//   waddr/wen/wdata         RF write port
//   fwd_valid/fwd_rd/fwd_data   bypass copy of the RF write
//   commit_valid, commit_pc one-cycle commit pulse and its PC
//   load_pending, pending_rd    outstanding-load hazard info
//   wb_err                  sticky load-timeout error
module wb_unit #(
    parameter int unsigned XLEN         = npc_pkg::XLEN,
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [4:0]      ex_rd,
    input  logic            ex_wen,
    input  logic            ex_is_load,
    input  logic [2:0]      ex_load_op,
    input  logic [2:0]      ex_addr_lo,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      waddr,
    output logic            wen,
    output logic [XLEN-1:0] wdata,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic            load_pending,
    output logic [4:0]      pending_rd,
    output logic            wb_err
);
    import npc_pkg::*;

    localparam int unsigned     CW       = $clog2(LOAD_TIMEOUT + 1);
    // Last counter value before giving up: WAIT_LOAD lasts at most
    // LOAD_TIMEOUT cycles.
    localparam logic [CW-1:0]   CNT_LAST = CW'(LOAD_TIMEOUT - 1);

    wb_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Latched load descriptor
    logic [XLEN-1:0] pc_q, pc_d;
    logic [4:0]      rd_q, rd_d;
    logic            lwen_q, lwen_d;
    logic [2:0]      op_q, op_d;
    logic [2:0]      addr_q, addr_d;

    // Registered outputs
    logic [4:0]      waddr_q, waddr_d;
    logic            wen_q, wen_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            commit_valid_q, commit_valid_d;
    logic [XLEN-1:0] commit_pc_q, commit_pc_d;
    logic            load_pending_q, load_pending_d;
    logic [4:0]      pending_rd_q, pending_rd_d;
    logic            wb_err_q, wb_err_d;

    logic [XLEN-1:0] load_data;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .rdata   (mem_rdata),
        .addr_lo (addr_q),
        .load_op (op_q),
        .result  (load_data)
    );

    // Held low while reset is asserted even though the state reads IDLE.
    assign ex_ready = reset & (state_q == IDLE);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_d           = pc_q;
        rd_d           = rd_q;
        lwen_d         = lwen_q;
        op_d           = op_q;
        addr_d         = addr_q;
        waddr_d        = waddr_q;
        wen_d          = 1'b0;
        wdata_d        = wdata_q;
        commit_valid_d = 1'b0;
        commit_pc_d    = commit_pc_q;
        wb_err_d       = wb_err_q;

        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_is_load) begin
                        pc_d    = ex_pc;
                        rd_d    = ex_rd;
                        lwen_d  = ex_wen;
                        op_d    = ex_load_op;
                        addr_d  = ex_addr_lo;
                        cnt_d   = '0;
                        state_d = WAIT_LOAD;
                    end else begin
                        commit_valid_d = 1'b1;
                        commit_pc_d    = ex_pc;
                        waddr_d        = ex_rd;
                        wen_d          = ex_wen & (ex_rd != 5'd0);
                        wdata_d        = ex_result;
                    end
                end
            end
            WAIT_LOAD: begin
                // Data arriving on the timeout cycle still completes normally.
                if (mem_rvalid || (cnt_q == CNT_LAST)) begin
                    commit_valid_d = 1'b1;
                    commit_pc_d    = pc_q;
                    waddr_d        = rd_q;
                    wen_d          = lwen_q & (rd_q != 5'd0);
                    wdata_d        = mem_rvalid ? load_data : '0;
                    wb_err_d       = wb_err_q | ~mem_rvalid;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        load_pending_d = (state_d == WAIT_LOAD);
        pending_rd_d   = load_pending_d ? rd_d : 5'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pc_q           <= '0;
            rd_q           <= '0;
            lwen_q         <= 1'b0;
            op_q           <= '0;
            addr_q         <= '0;
            waddr_q        <= '0;
            wen_q          <= 1'b0;
            wdata_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            load_pending_q <= 1'b0;
            pending_rd_q   <= '0;
            wb_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pc_q           <= pc_d;
            rd_q           <= rd_d;
            lwen_q         <= lwen_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            waddr_q        <= waddr_d;
            wen_q          <= wen_d;
            wdata_q        <= wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            load_pending_q <= load_pending_d;
            pending_rd_q   <= pending_rd_d;
            wb_err_q       <= wb_err_d;
        end
    end

    assign waddr        = waddr_q;
    assign wen          = wen_q;
    assign wdata        = wdata_q;
    assign fwd_valid    = wen_q;
    assign fwd_rd       = waddr_q;
    assign fwd_data     = wdata_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
    assign load_pending = load_pending_q;
    assign pending_rd   = pending_rd_q;
    assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

    localparam int unsigned XLEN         = 64;
    localparam int unsigned LOAD_TIMEOUT = 255;

    logic            clock;
    logic            reset;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rd;
    logic            ex_wen;
    logic            ex_is_load;
    logic [2:0]      ex_load_op;
    logic [2:0]      ex_addr_lo;
    logic [XLEN-1:0] ex_result;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic [4:0]      waddr;
    logic            wen;
    logic [XLEN-1:0] wdata;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            load_pending;
    logic [4:0]      pending_rd;
    logic            wb_err;

    int unsigned vectors;
    int unsigned miscompares;

    typedef struct {
        logic        is_load;
        logic [2:0]  op;
        logic [2:0]  addr;
        logic [63:0] rdata;
        logic [63:0] result;
        logic [4:0]  rd;
        logic        wen;
        int unsigned lat;
        logic        exp_wen;
        logic [63:0] exp_data;
    } vec_t;

    wb_unit #(.XLEN(XLEN), .LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_pc        (ex_pc),
        .ex_rd        (ex_rd),
        .ex_wen       (ex_wen),
        .ex_is_load   (ex_is_load),
        .ex_load_op   (ex_load_op),
        .ex_addr_lo   (ex_addr_lo),
        .ex_result    (ex_result),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .waddr        (waddr),
        .wen          (wen),
        .wdata        (wdata),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .load_pending (load_pending),
        .pending_rd   (pending_rd),
        .wb_err       (wb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference load result: pick the naturally aligned field of the given
    // size containing addr, then extend according to the signedness of op.
    function automatic logic [63:0] ref_load(input logic [2:0] op, input logic [2:0] a,
                                             input logic [63:0] d);
        int unsigned size;
        int unsigned off;
        logic [63:0] v;
        logic [63:0] mask;
        case (op)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2, 3'd6: size = 4;
            3'd3:       size = 8;
            default:    return 64'd0;
        endcase
        off = (int'(a) / size) * size;
        v = d >> (8 * off);
        if (size < 8) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            v = v & mask;
            if (op < 3'd4 && v[8*size-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic scramble_ex();
        ex_pc      = {$urandom, $urandom};
        ex_rd      = 5'($urandom);
        ex_wen     = 1'($urandom);
        ex_is_load = 1'($urandom);
        ex_load_op = 3'($urandom);
        ex_addr_lo = 3'($urandom);
        ex_result  = {$urandom, $urandom};
    endtask

    task automatic check_commit(input string tag, input logic [63:0] pc,
                                input logic ew, input logic [4:0] rd, input logic [63:0] d);
        chk({tag, ".commit_valid"}, commit_valid, 1);
        chk({tag, ".commit_pc"}, commit_pc, pc);
        chk({tag, ".wen"}, wen, ew);
        chk({tag, ".fwd_valid"}, fwd_valid, ew);
        if (ew) begin
            chk({tag, ".waddr"}, waddr, rd);
            chk({tag, ".wdata"}, wdata, d);
            chk({tag, ".fwd_rd"}, fwd_rd, rd);
            chk({tag, ".fwd_data"}, fwd_data, d);
        end
    endtask

    // Issue one instruction from IDLE, serve its load (if any) after v.lat
    // empty cycles, and check the resulting write/commit cycle.
    task automatic run_instr(input string tag, input vec_t v, input logic [63:0] pc);
        chk({tag, ".ready_idle"}, ex_ready, 1);
        ex_valid   = 1'b1;
        ex_pc      = pc;
        ex_rd      = v.rd;
        ex_wen     = v.wen;
        ex_is_load = v.is_load;
        ex_load_op = v.op;
        ex_addr_lo = v.addr;
        ex_result  = v.result;
        tick();
        ex_valid = 1'b0;
        scramble_ex();
        if (v.is_load) begin
            chk({tag, ".no_early_commit"}, commit_valid, 0);
            for (int unsigned i = 0; i < v.lat; i++) begin
                chk({tag, ".load_pending"}, load_pending, 1);
                chk({tag, ".ready_wait"}, ex_ready, 0);
                chk({tag, ".pending_rd"}, pending_rd, v.rd);
                mem_rdata = {$urandom, $urandom};
                tick();
            end
            chk({tag, ".load_pending_last"}, load_pending, 1);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
            chk({tag, ".ready_after"}, ex_ready, 1);
            chk({tag, ".pending_clear"}, load_pending, 0);
        end
        check_commit(tag, pc, v.exp_wen, v.rd, v.exp_data);
        tick();
        chk({tag, ".commit_pulse_end"}, commit_valid, 0);
        chk({tag, ".wen_pulse_end"}, wen, 0);
    endtask

    vec_t tbl[11];
    vec_t rv;
    logic [63:0] pc;

    initial begin
        vectors     = 0;
        miscompares = 0;

        //         load  op    addr  rdata                  result                 rd     wen   lat exp_wen exp_data
        tbl[0]  = '{1'b0, 3'd0, 3'd0, 64'h0,                 64'h0000_0000_DEAD_BEEF, 5'd5,  1'b1, 0, 1'b1, 64'h0000_0000_DEAD_BEEF};
        tbl[1]  = '{1'b1, 3'd0, 3'd3, 64'h0000_0000_8000_0000, 64'h0,                 5'd6,  1'b1, 4, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        tbl[2]  = '{1'b1, 3'd4, 3'd3, 64'h0000_0000_8000_0000, 64'h0,                 5'd6,  1'b1, 4, 1'b1, 64'h0000_0000_0000_0080};
        tbl[3]  = '{1'b1, 3'd2, 3'd4, 64'h8765_4321_0000_0000, 64'h0,                 5'd10, 1'b1, 1, 1'b1, 64'hFFFF_FFFF_8765_4321};
        tbl[4]  = '{1'b1, 3'd6, 3'd4, 64'h8765_4321_0000_0000, 64'h0,                 5'd11, 1'b1, 0, 1'b1, 64'h0000_0000_8765_4321};
        tbl[5]  = '{1'b1, 3'd3, 3'd0, 64'h8765_4321_0000_0000, 64'h0,                 5'd12, 1'b1, 2, 1'b1, 64'h8765_4321_0000_0000};
        tbl[6]  = '{1'b0, 3'd0, 3'd0, 64'h0,                 64'h1234_5678_9ABC_DEF0, 5'd0,  1'b1, 0, 1'b0, 64'h0};
        tbl[7]  = '{1'b1, 3'd1, 3'd3, 64'h0000_0000_F00D_1234, 64'h0,                 5'd13, 1'b1, 3, 1'b1, 64'hFFFF_FFFF_FFFF_F00D};
        tbl[8]  = '{1'b1, 3'd5, 3'd7, 64'h9ABC_0000_0000_0000, 64'h0,                 5'd14, 1'b1, 1, 1'b1, 64'h0000_0000_0000_9ABC};
        tbl[9]  = '{1'b1, 3'd7, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 5'd15, 1'b1, 0, 1'b1, 64'h0};
        tbl[10] = '{1'b1, 3'd3, 3'd0, 64'h1111_2222_3333_4444, 64'h0,                 5'd9,  1'b0, 2, 1'b0, 64'h0};

        reset      = 1'b0;
        ex_valid   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        scramble_ex();

        // Reset state
        tick();
        tick();
        chk("rst.ex_ready", ex_ready, 0);
        chk("rst.wen", wen, 0);
        chk("rst.commit_valid", commit_valid, 0);
        chk("rst.load_pending", load_pending, 0);
        chk("rst.wb_err", wb_err, 0);
        chk("rst.waddr", waddr, 0);
        chk("rst.wdata", wdata, 0);
        chk("rst.commit_pc", commit_pc, 0);
        chk("rst.pending_rd", pending_rd, 0);
        reset = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_instr($sformatf("tbl%0d", i), tbl[i], 64'h1000 + 64'(4 * i));
        end
        chk("tbl.wb_err", wb_err, 0);

        // Back-to-back non-loads, one per cycle
        chk("b2b.ready", ex_ready, 1);
        for (int i = 0; i < 4; i++) begin
            ex_valid   = 1'b1;
            ex_is_load = 1'b0;
            ex_wen     = 1'b1;
            ex_rd      = 5'(20 + i);
            ex_pc      = 64'h2000 + 64'(4 * i);
            ex_result  = 64'hA5A5_0000_0000_0000 + 64'(i);
            tick();
            if (i > 0) chk("b2b.ready_stream", ex_ready, 1);
            check_commit($sformatf("b2b%0d", i), 64'h2000 + 64'(4 * i), 1'b1,
                         5'(20 + i), 64'hA5A5_0000_0000_0000 + 64'(i));
        end
        ex_valid = 1'b0;
        tick();
        chk("b2b.end", commit_valid, 0);

        // mem_rvalid while idle has no effect
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFEED_FACE_CAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk("idle_rvalid.commit", commit_valid, 0);
        chk("idle_rvalid.wen", wen, 0);
        chk("idle_rvalid.pending", load_pending, 0);

        // Data on the timeout cycle completes normally
        rv = '{1'b1, 3'd2, 3'd0, 64'h0000_0000_7654_3210, 64'h0, 5'd17, 1'b1,
               LOAD_TIMEOUT - 1, 1'b1, 64'h0000_0000_7654_3210};
        run_instr("race", rv, 64'h3000);
        chk("race.wb_err", wb_err, 0);

        // Timeout: no data for LOAD_TIMEOUT cycles
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_load_op = 3'd3;
        ex_addr_lo = 3'd0;
        ex_rd      = 5'd18;
        ex_wen     = 1'b1;
        ex_pc      = 64'h4000;
        tick();
        ex_valid = 1'b0;
        scramble_ex();
        for (int unsigned i = 0; i < LOAD_TIMEOUT; i++) begin
            chk("to.pending", load_pending, 1);
            chk("to.no_err_yet", wb_err, 0);
            chk("to.no_commit", commit_valid, 0);
            tick();
        end
        check_commit("to", 64'h4000, 1'b1, 5'd18, 64'h0);
        chk("to.wb_err", wb_err, 1);
        chk("to.ready", ex_ready, 1);
        chk("to.pending_clear", load_pending, 0);
        tick();
        chk("to.pulse_end", commit_valid, 0);
        rv = '{1'b0, 3'd0, 3'd0, 64'h0, 64'h55, 5'd3, 1'b1, 0, 1'b1, 64'h55};
        run_instr("post_to", rv, 64'h4004);
        chk("to.sticky", wb_err, 1);

        // Reset while waiting for load data
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_load_op = 3'd3;
        ex_rd      = 5'd7;
        ex_wen     = 1'b1;
        ex_pc      = 64'h5000;
        tick();
        ex_valid = 1'b0;
        tick();
        tick();
        chk("mid.pending", load_pending, 1);
        reset = 1'b0;
        #1;
        chk("mid.ex_ready", ex_ready, 0);
        chk("mid.wen", wen, 0);
        chk("mid.wdata", wdata, 0);
        chk("mid.waddr", waddr, 0);
        chk("mid.commit_valid", commit_valid, 0);
        chk("mid.commit_pc", commit_pc, 0);
        chk("mid.load_pending", load_pending, 0);
        chk("mid.pending_rd", pending_rd, 0);
        chk("mid.wb_err", wb_err, 0);
        chk("mid.fwd_data", fwd_data, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        reset = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("mid.after_commit", commit_valid, 0);
        chk("mid.after_wen", wen, 0);
        chk("mid.after_pending", load_pending, 0);
        tick();
        chk("mid.after_commit2", commit_valid, 0);
        rv = '{1'b0, 3'd0, 3'd0, 64'h0, 64'h77, 5'd8, 1'b1, 0, 1'b1, 64'h77};
        run_instr("post_rst", rv, 64'h5004);

        // Randomized traffic against the reference model
        pc = 64'h8000;
        for (int i = 0; i < 60; i++) begin
            rv.is_load  = 1'($urandom_range(0, 1));
            rv.op       = 3'($urandom_range(0, 7));
            rv.addr     = 3'($urandom_range(0, 7));
            rv.rdata    = {$urandom, $urandom};
            rv.result   = {$urandom, $urandom};
            rv.rd       = 5'($urandom_range(0, 31));
            rv.wen      = ($urandom_range(0, 3) != 0);
            rv.lat      = $urandom_range(0, 6);
            rv.exp_wen  = rv.wen && (rv.rd != 5'd0);
            rv.exp_data = rv.is_load ? ref_load(rv.op, rv.addr, rv.rdata) : rv.result;
            run_instr($sformatf("rnd%0d", i), rv, pc);
            pc = pc + 64'd4;
        end
        chk("rnd.wb_err", wb_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
# wb_unit

Writeback stage sitting directly upstream of the integer register file's write port. Accepts one retiring instruction at a time from the execute/memory stage over a valid/ready handshake, waits for load data from the data-memory response channel when needed, sign/zero-extends it, and drives a registered single-cycle write (`waddr`/`wen`/`wdata`) into the RF. It also emits a commit pulse and a forwarding copy of the write for the operand-read logic, plus a load-timeout error flag.

## Interface
- `XLEN`, 64, datapath width.
- `LOAD_TIMEOUT`, 255, max cycles spent in WAIT_LOAD before error; counter width is `$clog2(LOAD_TIMEOUT+1)`.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  retiring instruction present.
- `ex_ready`  out  1  stage can accept.
- `ex_pc`  in  XLEN  instruction PC.
- `ex_rd`  in  5  destination register.
- `ex_wen`  in  1  instruction writes rd.
- `ex_is_load`  in  1  result comes from memory.
- `ex_load_op`  in  3  funct3 encoding: LB=0 LH=1 LW=2 LD=3 LBU=4 LHU=5 LWU=6.
- `ex_addr_lo`  in  3  load address bits [2:0].
- `ex_result`  in  XLEN  ALU/CSR result for non-loads.
- `mem_rvalid`  in  1  load data beat valid.
- `mem_rdata`  in  XLEN  aligned 64-bit doubleword containing the load.
- `waddr`  out  5  RF write address.
- `wen`  out  1  RF write enable.
- `wdata`  out  XLEN  RF write data.
- `fwd_valid`  out  1  equals `wen`; bypass is live.
- `fwd_rd`  out  5  equals `waddr`.
- `fwd_data`  out  XLEN  equals `wdata`.
- `commit_valid`  out  1  one-cycle commit pulse.
- `commit_pc`  out  XLEN  PC of committing instruction.
- `load_pending`  out  1  in WAIT_LOAD (hazard stall for upstream).
- `pending_rd`  out  5  rd of the outstanding load.
- `wb_err`  out  1  sticky load-timeout error.

## Operation
- States: IDLE, WAIT_LOAD.
- IDLE: `ex_ready`=1. On `ex_valid`: non-load → register write/commit, stay IDLE; load → latch pc, rd, wen, load_op, addr_lo; clear timeout counter; go WAIT_LOAD.
- WAIT_LOAD: `ex_ready`=0, `load_pending`=1. `mem_rvalid` ignored in IDLE. On `mem_rvalid` → extract, register write/commit, go IDLE. Counter increments each cycle without `mem_rvalid`; when it reaches `LOAD_TIMEOUT`: set `wb_err`, commit with `wdata`=0, go IDLE. `mem_rvalid` in the same cycle as the timeout wins (normal completion).
- Extraction: byte offset = `addr_lo`. LB/LBU take byte `addr_lo`; LH/LHU take halfword at `addr_lo & 6`; LW/LWU take word at `addr_lo & 4`; LD takes full beat. The lower `addr_lo` bits are ignored (misalignment handled upstream). Signed ops sign-extend to XLEN; U ops zero-extend. `load_op`=7 yields 0.
- `wen` = latched `ex_wen` AND rd≠0; the rd=0 write is suppressed but `commit_valid` still pulses.
- `wb_err` clears only on reset.

## Timing
- All outputs registered. Reset values: `wen`, `fwd_valid`, `commit_valid`, `load_pending`, `wb_err` = 0; `waddr`, `fwd_rd`, `pending_rd` = 0; `wdata`, `fwd_data`, `commit_pc` = 0; state = IDLE. `ex_ready` is combinational from state (0 during reset).
- Non-load: accepted at edge N → `wen`/`commit_valid` high for cycle N+1 only; the RF captures at edge N+1.
- Load: data at edge M (`mem_rvalid`) → write/commit during cycle M+1; `ex_ready` rises in cycle M+1.
- Back-to-back non-loads: one per cycle, no bubbles.
- Reset mid-WAIT_LOAD: the load is dropped and no write or commit occurs.

## Structure
- `npc_pkg`: `load_op_e` (LB..LWU), `wb_state_e` (IDLE, WAIT_LOAD), `XLEN` constant.
- Sub-module `load_ext`: combinational (`rdata`, `addr_lo`, `load_op`) → extended XLEN value.

## Test plan
- Non-load `ex_rd`=5, `ex_result`=0xDEAD_BEEF → next cycle `wen`=1, `waddr`=5, `wdata`=0xDEAD_BEEF, `commit_valid`=1 for exactly one cycle.
- LB with `addr_lo`=3, `mem_rdata`=0x0000_0000_8000_0000 after 4 cycles → `load_pending`=1 and `ex_ready`=0 for those cycles, then `wdata`=0xFFFF_FFFF_FFFF_FF80. Repeat as LBU → 0x80.
- LW `addr_lo`=4, `mem_rdata`=0x8765_4321_0000_0000 → 0xFFFF_FFFF_8765_4321; LWU → 0x8765_4321; LD → full beat.
- Non-load with `ex_rd`=0, `ex_wen`=1 → `wen`=0, `commit_valid`=1.
- Load with no `mem_rvalid` for `LOAD_TIMEOUT` cycles → `wb_err`=1 (sticky), commit with `wdata`=0, state IDLE; `mem_rvalid` on the timeout cycle → normal data written and `wb_err` stays 0.
- Assert `reset` low while in WAIT_LOAD → all outputs 0 immediately; no write after release; next instruction accepted normally.
